// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory controller.
package imem_pkg;

   localparam int unsigned DEFAULT_DEPTH = 128;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

   typedef enum logic [0:0] {
      StLoad,
      StRun
   } state_e;

   // A fetch faults when it is not word-aligned or lies past the last word.
   function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Loader and CPU fetch signals of the instruction-memory controller.
interface imem_ctrl_if import imem_pkg::*; #(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic          ld_valid;
   logic [7:0]    ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          reload;
   logic          cpu_hold;
   logic          fetch_req;
   logic [31:0]   fetch_addr;
   logic          fetch_valid;
   logic [31:0]   fetch_instr;
   logic          fetch_fault;
   logic [AW:0]   load_words;

   // Controller side.
   modport slave (
      input  ld_valid, ld_data, ld_last, reload, fetch_req, fetch_addr,
      output ld_ready, cpu_hold, fetch_valid, fetch_instr, fetch_fault, load_words
   );

   // Loader / CPU side.
   modport master (
      output ld_valid, ld_data, ld_last, reload, fetch_req, fetch_addr,
      input  ld_ready, cpu_hold, fetch_valid, fetch_instr, fetch_fault, load_words
   );

endinterface

// File: rtl/imem_ram.sv
// Synchronous single-port DEPTH x 32 RAM; rdata only changes on a read.
module imem_ram #(
   parameter  int unsigned DEPTH = 128,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Single port: a write takes the port, otherwise an enabled read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: byte-serial loader in LOAD, CPU fetch port in RUN.
module imem_ctrl import imem_pkg::*; #(
   parameter  int unsigned DEPTH = DEFAULT_DEPTH,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic      clk,
   input  logic      reset_n,
   imem_ctrl_if.slave bus
);

   state_e        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [1:0]    bidx_q, bidx_d;
   logic [23:0]   buf_q, buf_d;
   logic [AW:0]   load_words_q, load_words_d;
   logic          fvalid_q, fvalid_d;
   logic          ffault_q, ffault_d;
   logic          from_ram_q, from_ram_d;

   logic          ram_we, ram_re;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata, ram_rdata;
   logic [31:0]   word_asm;
   logic          fault;
   logic          accept;

   imem_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Next-state for loader, state machine and fetch response.
   always_comb begin
      state_d      = state_q;
      wptr_d       = wptr_q;
      bidx_d       = bidx_q;
      buf_d        = buf_q;
      load_words_d = load_words_q;
      fvalid_d     = 1'b0;
      ffault_d     = ffault_q;
      from_ram_d   = from_ram_q;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      ram_addr     = wptr_q;
      // The buffer is cleared after every write, so unfilled upper bytes are zero.
      word_asm     = {8'h00, buf_q} | ({24'h000000, bus.ld_data} << {bidx_q, 3'b000});
      ram_wdata    = word_asm;
      fault        = addr_fault(bus.fetch_addr, DEPTH);
      accept       = bus.ld_valid && (state_q == StLoad);

      unique case (state_q)
         StLoad: begin
            if (accept) begin
               if ((bidx_q == 2'd3) || bus.ld_last) begin
                  ram_we       = 1'b1;
                  wptr_d       = wptr_q + 1'b1;
                  load_words_d = load_words_q + 1'b1;
                  bidx_d       = 2'd0;
                  buf_d        = 24'h000000;
                  if (bus.ld_last || (wptr_q == AW'(DEPTH - 1))) begin
                     state_d = StRun;
                  end
               end else begin
                  bidx_d = bidx_q + 2'd1;
                  buf_d  = word_asm[23:0];
               end
            end
         end
         StRun: begin
            if (bus.fetch_req) begin
               fvalid_d   = 1'b1;
               ffault_d   = fault;
               from_ram_d = !fault;
               ram_re     = !fault;
               ram_addr   = bus.fetch_addr[AW+1:2];
            end
            // A fetch in the same cycle is still answered; only the load state restarts.
            if (bus.reload) begin
               state_d      = StLoad;
               wptr_d       = '0;
               bidx_d       = 2'd0;
               buf_d        = 24'h000000;
               load_words_d = '0;
            end
         end
         default: state_d = StLoad;
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StLoad;
         wptr_q       <= '0;
         bidx_q       <= 2'd0;
         buf_q        <= 24'h000000;
         load_words_q <= '0;
         fvalid_q     <= 1'b0;
         ffault_q     <= 1'b0;
         from_ram_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         bidx_q       <= bidx_d;
         buf_q        <= buf_d;
         load_words_q <= load_words_d;
         fvalid_q     <= fvalid_d;
         ffault_q     <= ffault_d;
         from_ram_q   <= from_ram_d;
      end
   end

   assign bus.ld_ready    = reset_n && (state_q == StLoad);
   assign bus.cpu_hold    = !reset_n || (state_q == StLoad);
   assign bus.fetch_valid = fvalid_q;
   assign bus.fetch_fault = ffault_q;
   // RAM rdata only moves on a read, so the instruction holds between responses.
   assign bus.fetch_instr = from_ram_q ? ram_rdata : NOP_INSTR;
   assign bus.load_words  = load_words_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl: loads images, fetches and checks responses by queue.
module tb_imem_ctrl;
   import imem_pkg::*;

   localparam int unsigned DEPTH = 128;

   typedef struct {
      logic [31:0] instr;
      logic        fault;
      int          due;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   accepted;
   exp_t q[$];
   logic [7:0] img12 [12] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                              8'h63, 8'h88, 8'h20, 8'h00};
   logic [7:0] img5 [5]   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_ctrl_if #(.DEPTH(DEPTH)) bus ();

   imem_ctrl #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      @(posedge clk);
      #1;
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef,
                        input string nm);
      q.push_back('{instr: ei, fault: ef, due: cyc + 1, name: nm});
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      @(posedge clk);
      #1;
      bus.fetch_req = 1'b0;
   endtask

   task automatic pulse_reload();
      bus.reload = 1'b1;
      @(posedge clk);
      #1;
      bus.reload = 1'b0;
   endtask

   // Monitor: every response must match the head of the queue, on its due cycle.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && bus.fetch_valid === 1'b1) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got fetch_valid=1 instr=%h, expected no response",
                     bus.fetch_instr);
         end else begin
            e = q.pop_front();
            check32({e.name, "_instr"}, bus.fetch_instr, e.instr);
            check32({e.name, "_fault"}, 32'(bus.fetch_fault), 32'(e.fault));
            check32({e.name, "_cycle"}, cyc, e.due);
         end
      end
   end

   initial begin
      reset_n        = 1'b0;
      bus.ld_valid   = 1'b0;
      bus.ld_data    = 8'h00;
      bus.ld_last    = 1'b0;
      bus.reload     = 1'b0;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = 32'h0;
      #12;
      check32("rst_hold", 32'(bus.cpu_hold), 32'd1);
      check32("rst_ready", 32'(bus.ld_ready), 32'd0);
      check32("rst_valid", 32'(bus.fetch_valid), 32'd0);
      check32("rst_fault", 32'(bus.fetch_fault), 32'd0);
      check32("rst_instr", bus.fetch_instr, NOP_INSTR);
      check32("rst_words", 32'(bus.load_words), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check32("load_ready", 32'(bus.ld_ready), 32'd1);

      // Fetch and reload while loading are ignored (monitor flags any response).
      bus.fetch_req = 1'b1;
      bus.reload    = 1'b1;
      @(posedge clk);
      #1;
      bus.fetch_req = 1'b0;
      bus.reload    = 1'b0;
      @(posedge clk);
      #1;

      // Three-word image ending with ld_last on a full word.
      for (int i = 0; i < 12; i++) begin
         if (i == 11) check32("img12_hold_before", 32'(bus.cpu_hold), 32'd1);
         send_byte(img12[i], i == 11);
      end
      check32("img12_hold_after", 32'(bus.cpu_hold), 32'd0);
      check32("img12_ready_after", 32'(bus.ld_ready), 32'd0);
      check32("img12_words", 32'(bus.load_words), 32'd3);
      fetch(32'h0, 32'h0010_0093, 1'b0, "f0");
      fetch(32'h4, 32'h0010_0113, 1'b0, "f4");
      fetch(32'h8, 32'h0020_8863, 1'b0, "f8");
      fetch(32'h2, NOP_INSTR, 1'b1, "f_misal");
      fetch(32'h200, NOP_INSTR, 1'b1, "f_range");
      @(posedge clk);
      #1;
      check32("hold_valid", 32'(bus.fetch_valid), 32'd0);
      check32("hold_instr", bus.fetch_instr, NOP_INSTR);
      check32("hold_fault", 32'(bus.fetch_fault), 32'd1);

      // Partial last word is zero-padded; old word 2 survives the reload.
      pulse_reload();
      check32("reload_hold", 32'(bus.cpu_hold), 32'd1);
      check32("reload_words", 32'(bus.load_words), 32'd0);
      for (int i = 0; i < 5; i++) send_byte(img5[i], i == 4);
      check32("img5_words", 32'(bus.load_words), 32'd2);
      check32("img5_hold", 32'(bus.cpu_hold), 32'd0);
      fetch(32'h0, 32'hDDCC_BBAA, 1'b0, "g0");
      fetch(32'h4, 32'h0000_00EE, 1'b0, "g4");
      fetch(32'h8, 32'h0020_8863, 1'b0, "g8_kept");

      // Full memory without ld_last: stops after byte 512.
      pulse_reload();
      accepted = 0;
      for (int j = 0; j < 520; j++) begin
         if (bus.ld_ready) accepted++;
         send_byte(8'(j), 1'b0);
      end
      check32("full_accepted", 32'(accepted), 32'd512);
      check32("full_words", 32'(bus.load_words), 32'd128);
      check32("full_ready", 32'(bus.ld_ready), 32'd0);
      check32("full_hold", 32'(bus.cpu_hold), 32'd0);
      fetch(32'h0, 32'h0302_0100, 1'b0, "h0");
      fetch(32'h1FC, 32'hFFFE_FDFC, 1'b0, "h1fc");
      fetch(32'h200, NOP_INSTR, 1'b1, "h200");
      fetch(32'h1FE, NOP_INSTR, 1'b1, "h1fe");

      // Reload together with a fetch: the fetch is still answered.
      q.push_back('{instr: 32'h0706_0504, fault: 1'b0, due: cyc + 1, name: "rl_f4"});
      bus.reload     = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h4;
      @(posedge clk);
      #1;
      bus.reload    = 1'b0;
      bus.fetch_req = 1'b0;
      check32("rl_hold", 32'(bus.cpu_hold), 32'd1);
      check32("rl_ready", 32'(bus.ld_ready), 32'd1);
      check32("rl_words", 32'(bus.load_words), 32'd0);

      // Reset in the middle of a load.
      for (int i = 0; i < 6; i++) send_byte(8'(i + 16), 1'b0);
      check32("mid_words", 32'(bus.load_words), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check32("mid_rst_hold", 32'(bus.cpu_hold), 32'd1);
      check32("mid_rst_words", 32'(bus.load_words), 32'd0);
      check32("mid_rst_valid", 32'(bus.fetch_valid), 32'd0);
      check32("mid_rst_ready", 32'(bus.ld_ready), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check32("queue_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
